// File: rtl/m68k_bus_ctrl_pkg.sv
// Shared types and constants for the 68000 bus controller.
// Holds the FSM state encoding, the interrupt-acknowledge function code and bus widths.
package m68k_bus_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_ACK  = 3'd2,
    ST_TOUT = 3'd3,
    ST_BERR = 3'd4
  } state_t;

  localparam logic [2:0] FC_IACK = 3'b111;
  localparam int         DATA_W  = 16;
  localparam int         DEF_WW  = 4;

endpackage

// File: rtl/m68k_region_decode.sv
// Combinational priority decoder: compares the address field against each region base.
// Zero latency; lowest region index wins when bases overlap.
module m68k_region_decode
  import m68k_bus_ctrl_pkg::*;
#(
  parameter int                       NUM_REGIONS = 4,
  parameter int                       DW          = 4,
  parameter int                       IW          = 2,
  parameter logic [NUM_REGIONS*DW-1:0] REGION_BASE = '0
) (
  input  logic [DW-1:0] field,
  output logic          hit,
  output logic [IW-1:0] idx
);

  // Scan downward so the lowest matching index is the last assignment.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (field == REGION_BASE[i*DW +: DW]) begin
        hit = 1'b1;
        idx = i[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/m68k_bus_ctrl.sv
// 68000 bus controller: region chip selects, wait-state DTACKn, VPAn for 6800/IACK, BERRn timeout.
// Termination appears WAIT_i+1 cycles after AS sampled low; held until the CPU drops AS.
module m68k_bus_ctrl
  import m68k_bus_ctrl_pkg::*;
#(
  parameter int                                NUM_REGIONS = 4,
  parameter int                                DEC_HI      = 15,
  parameter int                                DEC_LO      = 12,
  parameter int                                WW          = DEF_WW,
  parameter logic [NUM_REGIONS*(DEC_HI-DEC_LO+1)-1:0] REGION_BASE = {4'h3, 4'h2, 4'h1, 4'h0},
  parameter logic [NUM_REGIONS*WW-1:0]         REGION_WAIT = {4'd0, 4'd0, 4'd0, 4'd0},
  parameter logic [NUM_REGIONS-1:0]            REGION_VPA  = 4'b0000,
  parameter int                                TIMEOUT     = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [23:1]                   addr,
  input  logic                          as_n,
  input  logic                          rw,
  input  logic                          uds_n,
  input  logic                          lds_n,
  input  logic [2:0]                    fc,
  input  logic [DATA_W*NUM_REGIONS-1:0] region_din,
  output logic [NUM_REGIONS-1:0]        cs,
  output logic                          we,
  output logic [1:0]                    be,
  output logic [DATA_W-1:0]             cpu_din,
  output logic                          dtack_n,
  output logic                          vpa_n,
  output logic                          berr_n
);

  localparam int DW = DEC_HI - DEC_LO + 1;
  localparam int IW = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
  localparam int TW = $clog2(TIMEOUT);
  localparam int CW = (WW > TW) ? WW : TW;
  localparam logic [CW-1:0] TOUT_LOAD = CW'(TIMEOUT - 1);

  state_t               state, state_nxt;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic                 vpa_term, vpa_term_nxt;
  logic [NUM_REGIONS-1:0] cs_nxt;
  logic                 we_nxt, dtack_nxt, vpa_nxt, berr_nxt;
  logic [1:0]           be_nxt;

  logic                 dec_hit;
  logic [IW-1:0]        dec_idx;
  logic [WW-1:0]        wait_sel;

  // Only the decoded field is looked at; the rest of the address bus is don't-care here.
  logic unused_addr;
  assign unused_addr = ^addr;

  m68k_region_decode #(
    .NUM_REGIONS (NUM_REGIONS),
    .DW          (DW),
    .IW          (IW),
    .REGION_BASE (REGION_BASE)
  ) u_decode (
    .field (addr[DEC_HI:DEC_LO]),
    .hit   (dec_hit),
    .idx   (dec_idx)
  );

  always_comb begin
    wait_sel = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (dec_idx == i[IW-1:0]) wait_sel = REGION_WAIT[i*WW +: WW];
    end
  end

  always_comb begin
    cpu_din = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (cs[i]) cpu_din = region_din[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    vpa_term_nxt = vpa_term;
    cs_nxt       = cs;
    we_nxt       = we;
    be_nxt       = be;
    dtack_nxt    = 1'b1;
    vpa_nxt      = 1'b1;
    berr_nxt     = 1'b1;

    // Strobes may settle late in a write, so track them while a region is selected.
    if (|cs) begin
      we_nxt = !rw;
      be_nxt = {!uds_n, !lds_n};
    end

    case (state)
      ST_IDLE: begin
        cs_nxt = '0;
        we_nxt = 1'b0;
        be_nxt = 2'b00;
        cnt_nxt = '0;
        if (!as_n) begin
          if (fc == FC_IACK) begin
            vpa_term_nxt = 1'b1;
            state_nxt    = ST_ACK;
          end else if (dec_hit) begin
            vpa_term_nxt    = REGION_VPA[dec_idx];
            cs_nxt[dec_idx] = 1'b1;
            we_nxt          = !rw;
            be_nxt          = {!uds_n, !lds_n};
            cnt_nxt         = '0;
            cnt_nxt[WW-1:0] = wait_sel;
            state_nxt       = (wait_sel == '0) ? ST_ACK : ST_WAIT;
          end else begin
            cnt_nxt   = TOUT_LOAD;
            state_nxt = ST_TOUT;
          end
        end
      end
      ST_WAIT: begin
        cnt_nxt = cnt - 1'b1;
        if (cnt == CW'(1)) state_nxt = ST_ACK;
      end
      ST_ACK: begin
        if (vpa_term) vpa_nxt = 1'b0;
        else          dtack_nxt = 1'b0;
      end
      ST_TOUT: begin
        if (cnt == '0) begin
          berr_nxt  = 1'b0;
          state_nxt = ST_BERR;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      ST_BERR: berr_nxt = 1'b0;
      default: state_nxt = ST_IDLE;
    endcase

    // Dropping AS ends any cycle in progress, with or without a termination.
    if (as_n && state != ST_IDLE) begin
      state_nxt    = ST_IDLE;
      cnt_nxt      = '0;
      vpa_term_nxt = 1'b0;
      cs_nxt       = '0;
      we_nxt       = 1'b0;
      be_nxt       = 2'b00;
      dtack_nxt    = 1'b1;
      vpa_nxt      = 1'b1;
      berr_nxt     = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      vpa_term <= 1'b0;
      cs       <= '0;
      we       <= 1'b0;
      be       <= 2'b00;
      dtack_n  <= 1'b1;
      vpa_n    <= 1'b1;
      berr_n   <= 1'b1;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      vpa_term <= vpa_term_nxt;
      cs       <= cs_nxt;
      we       <= we_nxt;
      be       <= be_nxt;
      dtack_n  <= dtack_nxt;
      vpa_n    <= vpa_nxt;
      berr_n   <= berr_nxt;
    end
  end

endmodule
